// File: rtl/lsu_port.sv
// lsu_port
// Load/store initiator for the data-side port of the shared dual-port RAM.
// Takes one request at a time, turns the RV32I funct3 width code into a word
// address, byte-write-enables and lane-replicated write data, and returns
// sign/zero-extended load data captured from the RAM's registered read port.
//
// Ports
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   req_valid/ready   : request handshake; ready only in IDLE and out of reset
//   req_we            : 1 = store, 0 = load
//   req_funct3        : RV32I width/sign code
//   req_addr          : byte address
//   req_wdata         : right-justified store data
//   resp_valid        : one-cycle completion pulse
//   resp_rdata        : extended load result (0 for stores and faults)
//   resp_misaligned   : access not naturally aligned
//   resp_illegal      : funct3/we combination not supported
//   mem_en/we/addr/wdata : RAM port B controls, active only in ACCESS
//   mem_rdata         : RAM read data, valid the cycle after mem_en
module lsu_port #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_misaligned,
  output logic                  resp_illegal,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            lane_q, lane_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_mis_q, resp_mis_d;
  logic                  resp_ill_q, resp_ill_d;

  logic        req_misaligned;
  logic        req_illegal;
  logic        access;
  logic [3:0]  byte_en;
  logic [31:0] wdata_repl;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_result;

  // Address bits above the RAM's word range are dropped so accesses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  assign req_ready = (state_q == ST_IDLE) && !rst;

  // funct3[1:0] gives the width; the reserved code 3 is checked like a word
  // so an illegal request can also report misalignment.
  assign req_misaligned = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                          (req_funct3[1] && (req_addr[1:0] != 2'b00));
  assign req_illegal    = (req_funct3 == 3'd3) ||
                          (req_funct3[2] && req_funct3[1]) ||
                          (req_we && req_funct3[2]);

  // RAM port drive: only in ACCESS, and never while reset is asserted.
  assign access = (state_q == ST_ACCESS) && !rst;

  always_comb begin
    byte_en    = 4'b1111;
    wdata_repl = wdata_q;
    case (funct3_q[1:0])
      2'd0: begin
        byte_en    = 4'b0001 << lane_q;
        wdata_repl = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        byte_en    = 4'b0011 << lane_q;
        wdata_repl = {2{wdata_q[15:0]}};
      end
      default: begin
        byte_en    = 4'b1111;
        wdata_repl = wdata_q;
      end
    endcase
  end

  assign mem_en    = access;
  assign mem_addr  = access ? addr_q : '0;
  assign mem_we    = (access && we_q) ? byte_en : 4'b0000;
  assign mem_wdata = (access && we_q) ? wdata_repl : 32'h0;

  // Load extraction; funct3[2] selects zero extension.
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (lane_q)
      2'd0: ld_byte = mem_rdata[7:0];
      2'd1: ld_byte = mem_rdata[15:8];
      2'd2: ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q[1:0])
      2'd0: ld_result = funct3_q[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'd1: ld_result = funct3_q[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_result = mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    lane_d       = lane_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_mis_d   = resp_mis_q;
    resp_ill_d   = resp_ill_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          lane_d   = req_addr[1:0];
          addr_d   = req_addr[ADDR_WIDTH+1:2];
          wdata_d  = req_wdata;
          if (req_misaligned || req_illegal) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'h0;
            resp_mis_d   = req_misaligned;
            resp_ill_d   = req_illegal;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (we_q) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = 32'h0;
          resp_mis_d   = 1'b0;
          resp_ill_d   = 1'b0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = ld_result;
        resp_mis_d   = 1'b0;
        resp_ill_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'd0;
      lane_q       <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_mis_q   <= 1'b0;
      resp_ill_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      lane_q       <= lane_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_mis_q   <= resp_mis_d;
      resp_ill_q   <= resp_ill_d;
    end
  end

  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign resp_misaligned = resp_mis_q;
  assign resp_illegal    = resp_ill_q;

endmodule
